uart_tx_queue: RTL

Byte queue sitting directly upstream of the UART transmitter. It accepts bytes from the system side into a DEPTH-entry FIFO. It presents one byte at a time on the transmitter's data/send/busy handshake and holds data stable for the whole frame. It absorbs bursts so producers never need to watch transmitter busy.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_fifo.sv | 72 +++++++
 rtl/uart_tx_queue.sv | 91 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit-queue FSM encodings and line-level framing constants.
package uart_pkg;

  typedef enum logic [1:0] {
    sIdle = 2'd0,
    sLoad = 2'd1,
    sSend = 2'd2,
    sWait = 2'd3
  } tx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO with registered count, full/empty flags and a sticky overflow flag.
// A push is still accepted when full if a pop happens on the same edge.
module uart_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_push,
  input  logic [7:0]        i_data,
  input  logic              i_pop,
  output logic [7:0]        o_data,
  input  logic              i_clear_overflow,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overflow
);

  localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              pop_ok, push_ok, drop;

  assign o_full     = (count == FullCount);
  assign o_empty    = (count == '0);
  assign o_count    = count;
  assign o_overflow = overflow;
  assign o_data     = mem[rd_ptr];

  assign pop_ok  = i_pop && !o_empty;
  assign push_ok = i_push && (!o_full || pop_ok);
  assign drop    = i_push && !push_ok;

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Setting wins over a simultaneous clear.
      if (drop) begin
        overflow <= 1'b1;
      end else if (i_clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue in front of the UART transmitter: buffers bursts and presents one byte at a
// time on the data/send/busy handshake, holding data stable for the whole frame.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [7:0]      i_8_data,
  input  logic            i_write,
  output logic            o_full,
  output logic            o_empty,
  output logic [ADDR_W:0] o_count,
  output logic            o_overflow,
  input  logic            i_clear_overflow,
  output logic [7:0]      o_tx_data,
  output logic            o_tx_send,
  input  logic            i_tx_busy
);

  tx_state_e  c_state, n_state;
  logic       busy_meta, busy_s;
  logic       pop;
  logic [7:0] fifo_rdata;
  logic [7:0] tx_data;

  // i_tx_busy comes from the transmitter's divided-clock domain.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      busy_meta <= 1'b0;
      busy_s    <= 1'b0;
    end else begin
      busy_meta <= i_tx_busy;
      busy_s    <= busy_meta;
    end
  end

  uart_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_push           (i_write),
    .i_data           (i_8_data),
    .i_pop            (pop),
    .o_data           (fifo_rdata),
    .i_clear_overflow (i_clear_overflow),
    .o_full           (o_full),
    .o_empty          (o_empty),
    .o_count          (o_count),
    .o_overflow       (o_overflow)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      c_state <= sIdle;
    end else begin
      c_state <= n_state;
    end
  end

  always_comb begin
    n_state = c_state;
    unique case (c_state)
      sIdle: if (!o_empty && !busy_s) n_state = sLoad;
      sLoad: n_state = sSend;
      sSend: if (busy_s) n_state = sWait;
      sWait: if (!busy_s) n_state = sIdle;
      default: n_state = sIdle;
    endcase
  end

  assign pop = (c_state == sLoad);

  // Pure state decode, so the request to the transmitter cannot glitch.
  assign o_tx_send = (c_state == sSend);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tx_data <= 8'h00;
    end else if (pop) begin
      tx_data <= fifo_rdata;
    end
  end

  assign o_tx_data = tx_data;

endmodule
